pcs_autoneg_ctrl: RTL and testbench
===================================

Name: pcs_autoneg_ctrl

Overview:
Clause 37 (1000BASE-X) auto-negotiation controller that sequences the PCS transmit/receive path.
- Commands the PCS transmitter what to send: /C/ config ordered sets, /I/ idles or MAC data.
- Supplies the 16-bit config word carried in the /C/ sets.
- Consumes decoded received /C/ and /I/ events from the PCS receive side.
- Reports link/negotiation status and the link-partner ability to management.

Parameters:
LINK_TIMER_CYCLES, 1250000, link_timer length in clk_125 cycles (10 ms at 125 MHz); benches override with a small value.
LOCAL_ABILITY, 16'h01A0, advertised base page: FD bit5, PS1 bit7, PS2 bit8. Bit14 (ACK) must be 0.

Ports:
clk_125  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
an_enable  in  1  1 = run auto-negotiation; 0 = bypass straight to data
an_restart  in  1  single-cycle pulse, restarts negotiation
sync_ok  in  1  PCS receive synchronisation acquired
rx_config_valid  in  1  single-cycle pulse: one complete /C/ ordered set decoded
rx_config_reg  in  16  config word of that /C/; valid only with rx_config_valid
rx_idle  in  1  single-cycle pulse: one /I/ ordered set decoded
tx_xmit  out  2  0 = IDLE, 1 = CONFIG, 2 = DATA (3 unused)
tx_config_reg  out  16  config word the PCS transmits while tx_xmit = CONFIG
lp_ability  out  16  latched partner ability, bit14 masked to 0
an_complete  out  1  negotiation finished
link_up  out  1  link usable for MAC traffic
an_state  out  3  current state encoding, for debug

Behaviour:
- Reset values (asynchronous): state AN_ENABLE, tx_xmit = 1, tx_config_reg = 0, lp_ability = 0, an_complete = 0, link_up = 0, all counters 0.
- All outputs are registered. Output values take effect on the edge that enters the state.
- State encoding: AN_ENABLE=0, AN_RESTART=1, ABILITY_DETECT=2, ACK_DETECT=3, COMPLETE_ACK=4, IDLE_DETECT=5, LINK_OK=6, DISABLE_LINK_OK=7.
- Match logic (runs in every state):
  - On rx_config_valid, compare the word with bit14 masked against the previous masked word. Equal: cfg_cnt increments, saturating at 3. Different: cfg_cnt = 1. Store the new word.
  - rx_idle clears cfg_cnt and increments idle_cnt (saturating at 3).
  - rx_config_valid clears idle_cnt.
  - ability_match = (cfg_cnt == 3).
  - ack_match = ability_match and bit14 = 1 in the last 3 words (track with a separate ack counter, cleared on any word with ACK = 0).
  - zero_match = ability_match and stored masked word == 0.
  - idle_match = (idle_cnt == 3).
  - Simultaneous rx_config_valid and rx_idle: rx_config_valid wins.
  - Counters clear on every state transition, so each state sees fresh matches.
- Link timer:
  - Loaded with LINK_TIMER_CYCLES-1 on entry to AN_RESTART, COMPLETE_ACK and IDLE_DETECT.
  - Decrements to 0 and holds there. timer_done = (count == 0).
- Global priority, highest first:
  1. an_restart → AN_ENABLE.
  2. sync_ok = 0 while an_enable = 1 → AN_ENABLE.
  3. an_enable falling while in any AN state → AN_ENABLE.
- AN_ENABLE: tx_xmit = CONFIG, tx_config_reg = 0, an_complete = 0, link_up = 0. Next cycle: an_enable = 1 → AN_RESTART; otherwise → DISABLE_LINK_OK.
- AN_RESTART: tx_config_reg = 0. On timer_done → ABILITY_DETECT. Total state dwell = LINK_TIMER_CYCLES cycles.
- ABILITY_DETECT: tx_config_reg = LOCAL_ABILITY. ability_match and not zero_match → latch lp_ability = masked word, go to ACK_DETECT.
- ACK_DETECT: tx_config_reg = LOCAL_ABILITY | 16'h4000.
  - ack_match and masked word == lp_ability → COMPLETE_ACK.
  - ack_match with a different word (consistency fail) → AN_ENABLE.
  - zero_match → AN_ENABLE.
- COMPLETE_ACK: keeps the ACK word.
  - zero_match → AN_ENABLE.
  - timer_done and not zero_match → IDLE_DETECT.
- IDLE_DETECT: tx_xmit = IDLE.
  - zero_match → AN_ENABLE.
  - timer_done and idle_match → LINK_OK. idle_match before timer_done is remembered (idle_cnt saturates).
- LINK_OK: tx_xmit = DATA, an_complete = 1, link_up = 1.
  - ability_match (partner sending config again) → AN_ENABLE.
  - rx_idle has no effect.
- DISABLE_LINK_OK: tx_xmit = DATA, an_complete = 0, link_up = sync_ok (registered).
  - an_enable rising → AN_ENABLE.
  - an_restart is ignored unless an_enable = 1.
- Reset asserted mid-negotiation: immediate return to reset values. The timer is not resumed.

Test Plan:
All tests use LINK_TIMER_CYCLES = 16.
1. Reset release with an_enable = 1, sync_ok = 1 → AN_RESTART for 16 cycles with tx_config_reg = 0, then ABILITY_DETECT with tx_config_reg = 16'h01A0.
2. Partner sends 3× 16'h0020, then 3× 16'h4020, then 3× rx_idle → lp_ability = 16'h0020; ACK_DETECT tx word = 16'h41A0; COMPLETE_ACK lasts 16 cycles; LINK_OK reached after the idle timer; link_up = 1, tx_xmit = 2.
3. In ACK_DETECT, partner sends 3× 16'h4040 after 16'h0020 was latched → AN_ENABLE, then restart; lp_ability unchanged until the next ABILITY_DETECT match.
4. In LINK_OK, drop sync_ok for 1 cycle → next edge link_up = 0, an_complete = 0, tx_xmit = 1, state = 0.
5. an_enable = 0 from reset → DISABLE_LINK_OK after 1 cycle, tx_xmit = 2, link_up follows sync_ok with 1-cycle delay; an_restart pulse has no effect.
6. Alternating 16'h0020 / 16'h0021 words in ABILITY_DETECT → never leaves the state; an_restart pulse mid-timer in COMPLETE_ACK → AN_ENABLE next edge.

Source files
------------

// File: rtl/pcs_autoneg_ctrl_if.sv
// Bundle between the Clause 37 auto-negotiation controller and the PCS/management side.
// master drives the PCS receive events and management controls; slave is the controller.
interface pcs_autoneg_ctrl_if;
   logic        an_enable;
   logic        an_restart;
   logic        sync_ok;
   logic        rx_config_valid;
   logic [15:0] rx_config_reg;
   logic        rx_idle;
   logic [1:0]  tx_xmit;
   logic [15:0] tx_config_reg;
   logic [15:0] lp_ability;
   logic        an_complete;
   logic        link_up;
   logic [2:0]  an_state;

   modport master (
      output an_enable, an_restart, sync_ok, rx_config_valid, rx_config_reg, rx_idle,
      input  tx_xmit, tx_config_reg, lp_ability, an_complete, link_up, an_state
   );

   modport slave (
      input  an_enable, an_restart, sync_ok, rx_config_valid, rx_config_reg, rx_idle,
      output tx_xmit, tx_config_reg, lp_ability, an_complete, link_up, an_state
   );
endinterface

// File: rtl/pcs_autoneg_ctrl.sv
// Clause 37 (1000BASE-X) auto-negotiation controller: sequences what the PCS transmits
// (/C/, /I/ or data) from the received /C/ and /I/ event stream.
module pcs_autoneg_ctrl #(
   parameter int unsigned LINK_TIMER_CYCLES = 1250000,
   parameter logic [15:0] LOCAL_ABILITY     = 16'h01A0
) (
   input logic              clk_125,
   input logic              reset_n,
   pcs_autoneg_ctrl_if.slave bus
);

   localparam logic [2:0] AN_ENABLE       = 3'd0;
   localparam logic [2:0] AN_RESTART      = 3'd1;
   localparam logic [2:0] ABILITY_DETECT  = 3'd2;
   localparam logic [2:0] ACK_DETECT      = 3'd3;
   localparam logic [2:0] COMPLETE_ACK    = 3'd4;
   localparam logic [2:0] IDLE_DETECT     = 3'd5;
   localparam logic [2:0] LINK_OK         = 3'd6;
   localparam logic [2:0] DISABLE_LINK_OK = 3'd7;

   localparam logic [1:0] XMIT_IDLE   = 2'd0;
   localparam logic [1:0] XMIT_CONFIG = 2'd1;
   localparam logic [1:0] XMIT_DATA   = 2'd2;

   localparam int unsigned    TW         = $clog2(LINK_TIMER_CYCLES + 1);
   localparam logic [TW-1:0]  TIMER_LOAD = TW'(LINK_TIMER_CYCLES - 1);

   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [1:0]    r_cfg_cnt;
   logic [1:0]    r_idle_cnt;
   logic [1:0]    r_ack_cnt;
   logic [15:0]   r_last_word;
   logic          r_an_enable_d;
   logic [1:0]    r_tx_xmit;
   logic [15:0]   r_tx_config_reg;
   logic [15:0]   r_lp_ability;
   logic          r_an_complete;
   logic          r_link_up;

   logic [2:0]    w_next;
   logic [15:0]   w_masked;
   logic          w_ability_match;
   logic          w_ack_match;
   logic          w_zero_match;
   logic          w_idle_match;
   logic          w_timer_done;
   logic          w_an_rise;
   logic          w_an_fall;
   logic          w_transition;
   logic [1:0]    w_tx_xmit;
   logic [15:0]   w_tx_config_reg;

   assign w_masked        = bus.rx_config_reg & 16'hBFFF;
   assign w_ability_match = (r_cfg_cnt == 2'd3);
   assign w_ack_match     = w_ability_match && (r_ack_cnt == 2'd3);
   assign w_zero_match    = w_ability_match && (r_last_word == 16'h0000);
   assign w_idle_match    = (r_idle_cnt == 2'd3);
   assign w_timer_done    = (r_timer == '0);
   assign w_an_rise       = bus.an_enable && !r_an_enable_d;
   assign w_an_fall       = !bus.an_enable && r_an_enable_d;
   assign w_transition    = (w_next != r_state);

   // Global aborts first; in DISABLE_LINK_OK a restart only counts once AN is enabled.
   always_comb begin
      w_next = r_state;
      if (bus.an_restart && !(r_state == DISABLE_LINK_OK && !bus.an_enable))
         w_next = AN_ENABLE;
      else if (!bus.sync_ok && bus.an_enable)
         w_next = AN_ENABLE;
      else if (w_an_fall && r_state != DISABLE_LINK_OK)
         w_next = AN_ENABLE;
      else begin
         case (r_state)
            AN_ENABLE:       w_next = bus.an_enable ? AN_RESTART : DISABLE_LINK_OK;
            AN_RESTART:      if (w_timer_done) w_next = ABILITY_DETECT;
            ABILITY_DETECT:  if (w_ability_match && !w_zero_match) w_next = ACK_DETECT;
            ACK_DETECT: begin
               if (w_zero_match)
                  w_next = AN_ENABLE;
               else if (w_ack_match)
                  w_next = (r_last_word == r_lp_ability) ? COMPLETE_ACK : AN_ENABLE;
            end
            COMPLETE_ACK: begin
               if (w_zero_match)      w_next = AN_ENABLE;
               else if (w_timer_done) w_next = IDLE_DETECT;
            end
            IDLE_DETECT: begin
               if (w_zero_match)                      w_next = AN_ENABLE;
               else if (w_timer_done && w_idle_match) w_next = LINK_OK;
            end
            LINK_OK:         if (w_ability_match) w_next = AN_ENABLE;
            DISABLE_LINK_OK: if (w_an_rise) w_next = AN_ENABLE;
            default:         w_next = AN_ENABLE;
         endcase
      end
   end

   // Outputs are a function of the state being entered so they change on the entry edge.
   always_comb begin
      w_tx_xmit       = XMIT_CONFIG;
      w_tx_config_reg = r_tx_config_reg;
      case (w_next)
         AN_ENABLE, AN_RESTART: w_tx_config_reg = 16'h0000;
         ABILITY_DETECT:        w_tx_config_reg = LOCAL_ABILITY;
         ACK_DETECT:            w_tx_config_reg = LOCAL_ABILITY | 16'h4000;
         IDLE_DETECT:           w_tx_xmit = XMIT_IDLE;
         LINK_OK, DISABLE_LINK_OK: w_tx_xmit = XMIT_DATA;
         default:               w_tx_xmit = XMIT_CONFIG;
      endcase
   end

   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= AN_ENABLE;
         r_timer         <= '0;
         r_cfg_cnt       <= 2'd0;
         r_idle_cnt      <= 2'd0;
         r_ack_cnt       <= 2'd0;
         r_last_word     <= 16'h0000;
         r_an_enable_d   <= 1'b0;
         r_tx_xmit       <= XMIT_CONFIG;
         r_tx_config_reg <= 16'h0000;
         r_lp_ability    <= 16'h0000;
         r_an_complete   <= 1'b0;
         r_link_up       <= 1'b0;
      end else begin
         r_state         <= w_next;
         r_an_enable_d   <= bus.an_enable;
         r_tx_xmit       <= w_tx_xmit;
         r_tx_config_reg <= w_tx_config_reg;
         r_an_complete   <= (w_next == LINK_OK);
         r_link_up       <= (w_next == LINK_OK) || (w_next == DISABLE_LINK_OK && bus.sync_ok);

         if (r_state == ABILITY_DETECT && w_next == ACK_DETECT)
            r_lp_ability <= r_last_word;

         if (bus.rx_config_valid)
            r_last_word <= w_masked;

         // Every state transition starts its successor with fresh match history.
         if (w_transition) begin
            r_cfg_cnt  <= 2'd0;
            r_idle_cnt <= 2'd0;
            r_ack_cnt  <= 2'd0;
         end else if (bus.rx_config_valid) begin
            r_cfg_cnt  <= (w_masked != r_last_word) ? 2'd1 :
                          (r_cfg_cnt == 2'd3) ? 2'd3 : r_cfg_cnt + 2'd1;
            r_ack_cnt  <= !bus.rx_config_reg[14] ? 2'd0 :
                          (r_ack_cnt == 2'd3) ? 2'd3 : r_ack_cnt + 2'd1;
            r_idle_cnt <= 2'd0;
         end else if (bus.rx_idle) begin
            r_cfg_cnt  <= 2'd0;
            r_ack_cnt  <= 2'd0;
            r_idle_cnt <= (r_idle_cnt == 2'd3) ? 2'd3 : r_idle_cnt + 2'd1;
         end

         if (w_transition && (w_next == AN_RESTART || w_next == COMPLETE_ACK ||
                              w_next == IDLE_DETECT))
            r_timer <= TIMER_LOAD;
         else if (!w_timer_done)
            r_timer <= r_timer - 1'b1;
      end
   end

   assign bus.tx_xmit       = r_tx_xmit;
   assign bus.tx_config_reg = r_tx_config_reg;
   assign bus.lp_ability    = r_lp_ability;
   assign bus.an_complete   = r_an_complete;
   assign bus.link_up       = r_link_up;
   assign bus.an_state      = r_state;

endmodule

// File: tb/tb_pcs_autoneg_ctrl.sv
// Directed bench for pcs_autoneg_ctrl with a 16-cycle link timer; expected values are
// hand-derived cycle counts and words for each negotiation scenario.
module tb_pcs_autoneg_ctrl;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   pcs_autoneg_ctrl_if anIf ();

   pcs_autoneg_ctrl #(.LINK_TIMER_CYCLES(16), .LOCAL_ABILITY(16'h01A0)) dut (
      .clk_125 (clk),
      .reset_n (reset_n),
      .bus     (anIf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic anEn, input logic sync);
      reset_n = 1'b0;
      anIf.an_enable = anEn;
      anIf.sync_ok = sync;
      anIf.an_restart = 1'b0;
      anIf.rx_config_valid = 1'b0;
      anIf.rx_config_reg = 16'h0000;
      anIf.rx_idle = 1'b0;
      tick(2);
      reset_n = 1'b1;
   endtask

   task automatic send_cfg(input logic [15:0] word);
      anIf.rx_config_valid = 1'b1;
      anIf.rx_config_reg = word;
      tick(1);
      anIf.rx_config_valid = 1'b0;
      anIf.rx_config_reg = 16'h0000;
   endtask

   task automatic send_idle();
      anIf.rx_idle = 1'b1;
      tick(1);
      anIf.rx_idle = 1'b0;
   endtask

   // Reset release plus the full 16-cycle AN_RESTART dwell.
   task automatic goto_ability();
      do_reset(1'b1, 1'b1);
      tick(17);
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      tick(3);
      checks++; if (anIf.an_state !== 3'd1) begin errors++; $display("[TB] FAIL reset_pre_state got %0d expected 1", anIf.an_state); end
      reset_n = 1'b0;
      #1;
      checks++; if (anIf.an_state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state got %0d expected 0", anIf.an_state); end
      checks++; if (anIf.tx_xmit !== 2'd1) begin errors++; $display("[TB] FAIL reset_xmit got %0d expected 1", anIf.tx_xmit); end
      checks++; if (anIf.tx_config_reg !== 16'h0000) begin errors++; $display("[TB] FAIL reset_txcfg got %h expected 0000", anIf.tx_config_reg); end
      checks++; if (anIf.lp_ability !== 16'h0000) begin errors++; $display("[TB] FAIL reset_lp got %h expected 0000", anIf.lp_ability); end
      checks++; if ({anIf.an_complete, anIf.link_up} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b expected 00", {anIf.an_complete, anIf.link_up}); end
   endtask

   task automatic test_restart_timing();
      do_reset(1'b1, 1'b1);
      checks++; if (anIf.an_state !== 3'd0) begin errors++; $display("[TB] FAIL rst_release_state got %0d expected 0", anIf.an_state); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd1) begin errors++; $display("[TB] FAIL restart_entry got %0d expected 1", anIf.an_state); end
      checks++; if (anIf.tx_config_reg !== 16'h0000) begin errors++; $display("[TB] FAIL restart_txcfg got %h expected 0000", anIf.tx_config_reg); end
      tick(15);
      checks++; if (anIf.an_state !== 3'd1) begin errors++; $display("[TB] FAIL restart_dwell got %0d expected 1", anIf.an_state); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd2) begin errors++; $display("[TB] FAIL ability_entry got %0d expected 2", anIf.an_state); end
      checks++; if (anIf.tx_config_reg !== 16'h01A0) begin errors++; $display("[TB] FAIL ability_txcfg got %h expected 01a0", anIf.tx_config_reg); end
      checks++; if (anIf.tx_xmit !== 2'd1) begin errors++; $display("[TB] FAIL ability_xmit got %0d expected 1", anIf.tx_xmit); end
   endtask

   task automatic test_full_negotiation();
      goto_ability();
      repeat (3) send_cfg(16'h0020);
      checks++; if (anIf.an_state !== 3'd2) begin errors++; $display("[TB] FAIL neg_still_ability got %0d expected 2", anIf.an_state); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd3) begin errors++; $display("[TB] FAIL neg_ack_entry got %0d expected 3", anIf.an_state); end
      checks++; if (anIf.lp_ability !== 16'h0020) begin errors++; $display("[TB] FAIL neg_lp got %h expected 0020", anIf.lp_ability); end
      checks++; if (anIf.tx_config_reg !== 16'h41A0) begin errors++; $display("[TB] FAIL neg_ack_txcfg got %h expected 41a0", anIf.tx_config_reg); end
      repeat (3) send_cfg(16'h4020);
      tick(1);
      checks++; if (anIf.an_state !== 3'd4) begin errors++; $display("[TB] FAIL neg_cack_entry got %0d expected 4", anIf.an_state); end
      tick(15);
      checks++; if (anIf.an_state !== 3'd4) begin errors++; $display("[TB] FAIL neg_cack_dwell got %0d expected 4", anIf.an_state); end
      checks++; if (anIf.tx_config_reg !== 16'h41A0) begin errors++; $display("[TB] FAIL neg_cack_txcfg got %h expected 41a0", anIf.tx_config_reg); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd5) begin errors++; $display("[TB] FAIL neg_idle_entry got %0d expected 5", anIf.an_state); end
      checks++; if (anIf.tx_xmit !== 2'd0) begin errors++; $display("[TB] FAIL neg_idle_xmit got %0d expected 0", anIf.tx_xmit); end
      repeat (3) send_idle();
      tick(12);
      checks++; if (anIf.an_state !== 3'd5) begin errors++; $display("[TB] FAIL neg_idle_dwell got %0d expected 5", anIf.an_state); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd6) begin errors++; $display("[TB] FAIL neg_linkok got %0d expected 6", anIf.an_state); end
      checks++; if ({anIf.link_up, anIf.an_complete} !== 2'b11) begin errors++; $display("[TB] FAIL neg_linkok_flags got %b expected 11", {anIf.link_up, anIf.an_complete}); end
      checks++; if (anIf.tx_xmit !== 2'd2) begin errors++; $display("[TB] FAIL neg_linkok_xmit got %0d expected 2", anIf.tx_xmit); end
      repeat (3) send_idle();
      tick(1);
      checks++; if (anIf.an_state !== 3'd6) begin errors++; $display("[TB] FAIL linkok_idle_ignored got %0d expected 6", anIf.an_state); end
   endtask

   task automatic test_sync_loss();
      anIf.sync_ok = 1'b0;
      tick(1);
      anIf.sync_ok = 1'b1;
      checks++; if (anIf.an_state !== 3'd0) begin errors++; $display("[TB] FAIL sync_loss_state got %0d expected 0", anIf.an_state); end
      checks++; if ({anIf.link_up, anIf.an_complete} !== 2'b00) begin errors++; $display("[TB] FAIL sync_loss_flags got %b expected 00", {anIf.link_up, anIf.an_complete}); end
      checks++; if (anIf.tx_xmit !== 2'd1) begin errors++; $display("[TB] FAIL sync_loss_xmit got %0d expected 1", anIf.tx_xmit); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd1) begin errors++; $display("[TB] FAIL sync_loss_restart got %0d expected 1", anIf.an_state); end
   endtask

   task automatic test_ack_mismatch();
      goto_ability();
      repeat (3) send_cfg(16'h0020);
      tick(1);
      checks++; if (anIf.an_state !== 3'd3) begin errors++; $display("[TB] FAIL mis_ack_entry got %0d expected 3", anIf.an_state); end
      repeat (3) send_cfg(16'h4040);
      checks++; if (anIf.an_state !== 3'd3) begin errors++; $display("[TB] FAIL mis_still_ack got %0d expected 3", anIf.an_state); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd0) begin errors++; $display("[TB] FAIL mis_abort got %0d expected 0", anIf.an_state); end
      checks++; if (anIf.lp_ability !== 16'h0020) begin errors++; $display("[TB] FAIL mis_lp_kept got %h expected 0020", anIf.lp_ability); end
      tick(17);
      checks++; if (anIf.an_state !== 3'd2) begin errors++; $display("[TB] FAIL mis_reability got %0d expected 2", anIf.an_state); end
      checks++; if (anIf.lp_ability !== 16'h0020) begin errors++; $display("[TB] FAIL mis_lp_hold got %h expected 0020", anIf.lp_ability); end
      repeat (3) send_cfg(16'hC080);
      tick(1);
      checks++; if (anIf.lp_ability !== 16'h8080) begin errors++; $display("[TB] FAIL mis_lp_masked got %h expected 8080", anIf.lp_ability); end
   endtask

   task automatic test_disable();
      do_reset(1'b0, 1'b1);
      tick(1);
      checks++; if (anIf.an_state !== 3'd7) begin errors++; $display("[TB] FAIL dis_state got %0d expected 7", anIf.an_state); end
      checks++; if (anIf.tx_xmit !== 2'd2) begin errors++; $display("[TB] FAIL dis_xmit got %0d expected 2", anIf.tx_xmit); end
      checks++; if ({anIf.link_up, anIf.an_complete} !== 2'b10) begin errors++; $display("[TB] FAIL dis_flags got %b expected 10", {anIf.link_up, anIf.an_complete}); end
      anIf.sync_ok = 1'b0;
      #1;
      checks++; if (anIf.link_up !== 1'b1) begin errors++; $display("[TB] FAIL dis_link_delay got %b expected 1", anIf.link_up); end
      tick(1);
      checks++; if (anIf.link_up !== 1'b0) begin errors++; $display("[TB] FAIL dis_link_drop got %b expected 0", anIf.link_up); end
      anIf.sync_ok = 1'b1;
      tick(1);
      checks++; if (anIf.link_up !== 1'b1) begin errors++; $display("[TB] FAIL dis_link_back got %b expected 1", anIf.link_up); end
      anIf.an_restart = 1'b1;
      tick(1);
      anIf.an_restart = 1'b0;
      checks++; if (anIf.an_state !== 3'd7) begin errors++; $display("[TB] FAIL dis_restart_ignored got %0d expected 7", anIf.an_state); end
      anIf.an_enable = 1'b1;
      tick(1);
      checks++; if (anIf.an_state !== 3'd0) begin errors++; $display("[TB] FAIL dis_enable_rise got %0d expected 0", anIf.an_state); end
      tick(1);
      checks++; if (anIf.an_state !== 3'd1) begin errors++; $display("[TB] FAIL dis_to_restart got %0d expected 1", anIf.an_state); end
   endtask

   task automatic test_no_match_and_restart();
      goto_ability();
      repeat (3) send_cfg(16'h0000);
      tick(2);
      checks++; if (anIf.an_state !== 3'd2) begin errors++; $display("[TB] FAIL zero_stays got %0d expected 2", anIf.an_state); end
      for (int i = 0; i < 6; i++) send_cfg((i % 2 == 0) ? 16'h0020 : 16'h0021);
      tick(2);
      checks++; if (anIf.an_state !== 3'd2) begin errors++; $display("[TB] FAIL alt_stays got %0d expected 2", anIf.an_state); end
      repeat (3) send_cfg(16'h0020);
      tick(1);
      repeat (3) send_cfg(16'h4020);
      tick(1);
      checks++; if (anIf.an_state !== 3'd4) begin errors++; $display("[TB] FAIL rs_cack got %0d expected 4", anIf.an_state); end
      tick(5);
      anIf.an_restart = 1'b1;
      tick(1);
      anIf.an_restart = 1'b0;
      checks++; if (anIf.an_state !== 3'd0) begin errors++; $display("[TB] FAIL rs_abort got %0d expected 0", anIf.an_state); end
      checks++; if (anIf.tx_config_reg !== 16'h0000) begin errors++; $display("[TB] FAIL rs_txcfg got %h expected 0000", anIf.tx_config_reg); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      do_reset(1'b1, 1'b1);
      test_reset();
      test_restart_timing();
      test_full_negotiation();
      test_sync_loss();
      test_ack_mismatch();
      test_disable();
      test_no_match_and_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
